rf_multiport: RTL and testbench

Parametrised general-purpose register file for the simple processor, succeeding the single-port 8-bit/16-entry file. It provides one write port, two independent registered read ports with write-to-read bypass, a flat read-only export of the low registers, and a sequential hardware clear engine. It sits between the instruction decoder (address/enable source) and the ALU/output logic (read consumers and export bus).

---
 rtl/rf_multiport.sv | 165 ++++++++++++++++
 tb/tb_rf_multiport.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport.sv
// -----------------------------------------------------------------------------
// rf_multiport
// General-purpose register file for the simple processor: one write port,
// two independent registered read ports with write-first bypass, a flat
// export of the low NRO registers, and a sequential clear engine that walks
// the whole array writing CLR_VAL, one entry per cycle.
//
// Ports
//   clk              clock, all state updates on posedge
//   rst              asynchronous active-high reset
//   we/waddr/wdata   write port (accepted only while the clear engine is idle)
//   re_a/raddr_a     read request, port A
//   rdata_a/rvld_a   registered read data / valid pulse, port A
//   re_b/raddr_b     read request, port B
//   rdata_b/rvld_b   registered read data / valid pulse, port B
//   clr_req          start a full-array clear (ignored while clearing)
//   busy             clear engine active
//   wr_err           one-cycle pulse after a write dropped during a clear
//   rf_data          {reg[NRO-1], ..., reg[0]}, straight from the array
// -----------------------------------------------------------------------------
module rf_multiport #(
   parameter int            DW      = 8,
   parameter int            AW      = 4,
   parameter int            NRO     = 5,
   parameter logic [DW-1:0] CLR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DW-1:0]     wdata,
   input  logic              re_a,
   input  logic [AW-1:0]     raddr_a,
   output logic [DW-1:0]     rdata_a,
   output logic              rvld_a,
   input  logic              re_b,
   input  logic [AW-1:0]     raddr_b,
   output logic [DW-1:0]     rdata_b,
   output logic              rvld_b,
   input  logic              clr_req,
   output logic              busy,
   output logic              wr_err,
   output logic [NRO*DW-1:0] rf_data
);

   localparam int            DEPTH = 1 << AW;
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [DW-1:0] regs_q [DEPTH];
   logic [DW-1:0] regs_d [DEPTH];
   logic [DW-1:0] rdata_a_q, rdata_b_q;
   logic          rvld_a_q, rvld_b_q;
   logic          wr_err_q;
   logic          wr_acc_s;
   logic [DW-1:0] rd_a_s, rd_b_s;

   assign wr_acc_s = we && (state_q == IDLE);

   // Clear-engine next state and pointer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            if (ptr_q == LAST) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d   = ptr_q + AW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Array next state: an accepted write or the clear of the current entry.
   // The two are mutually exclusive because writes are only taken in IDLE.
   always_comb begin
      regs_d = regs_q;
      if (wr_acc_s) begin
         regs_d[waddr] = wdata;
      end else begin
         if (state_q == CLEAR) begin
            regs_d[ptr_q] = CLR_VAL;
         end else begin
            regs_d[ptr_q] = regs_q[ptr_q];
         end
      end
   end

   // Reading from the next-state array gives write-first bypass and returns
   // CLR_VAL for the entry being cleared this cycle, with no extra muxing.
   always_comb begin
      rd_a_s = regs_d[raddr_a];
      rd_b_s = regs_d[raddr_b];
   end

   // Array storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= CLR_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Control state, read ports and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         rvld_a_q  <= 1'b0;
         rvld_b_q  <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         rvld_a_q <= re_a;
         rvld_b_q <= re_b;
         wr_err_q <= we && (state_q == CLEAR);
         if (re_a) begin
            rdata_a_q <= rd_a_s;
         end
         if (re_b) begin
            rdata_b_q <= rd_b_s;
         end
      end
   end

   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;
   assign rvld_a  = rvld_a_q;
   assign rvld_b  = rvld_b_q;
   assign wr_err  = wr_err_q;
   assign busy    = (state_q == CLEAR);

   for (genvar g = 0; g < NRO; g++) begin : g_export
      assign rf_data[g*DW +: DW] = regs_q[g];
   end

endmodule

// File: tb/tb_rf_multiport.sv
module tb_rf_multiport;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [3:0]  waddr = 4'd0;
   logic [7:0]  wdata = 8'h00;
   logic        re_a = 1'b0;
   logic [3:0]  raddr_a = 4'd0;
   logic [7:0]  rdata_a;
   logic        rvld_a;
   logic        re_b = 1'b0;
   logic [3:0]  raddr_b = 4'd0;
   logic [7:0]  rdata_b;
   logic        rvld_b;
   logic        clr_req = 1'b0;
   logic        busy;
   logic        wr_err;
   logic [39:0] rf_data;

   int n_cmp = 0;
   int n_err = 0;
   int fall;

   rf_multiport dut (
      .clk(clk), .rst(rst),
      .we(we), .waddr(waddr), .wdata(wdata),
      .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvld_a(rvld_a),
      .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvld_b(rvld_b),
      .clr_req(clr_req), .busy(busy), .wr_err(wr_err), .rf_data(rf_data)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // ---------------- reset state ----------------
      #12 rst = 1'b0;
      chk("rst_rf_data", 64'(rf_data), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_rvld", 64'({rvld_a, rvld_b}), 64'h0);
      chk("rst_wr_err", 64'(wr_err), 64'h0);

      // fill all with A5 then async reset between edges
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; waddr = 4'(i); wdata = 8'hA5;
         cyc();
      end
      we = 1'b0;
      chk("fill_a5_rf_data", 64'(rf_data), 64'hA5A5A5A5A5);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_rf_data", 64'(rf_data), 64'h0);
      chk("async_rst_busy", 64'(busy), 64'h0);
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         re_a = 1'b1; raddr_a = 4'(i);
         re_b = 1'b1; raddr_b = 4'(i + 8);
         cyc();
         chk("rst_read_a", 64'(rdata_a), 64'h0);
         chk("rst_read_b", 64'(rdata_b), 64'h0);
      end
      re_a = 1'b0; re_b = 1'b0;

      // ---------------- write / read ----------------
      we = 1'b1; waddr = 4'd3; wdata = 8'h3C;
      cyc();
      waddr = 4'd15; wdata = 8'hF0;
      cyc();
      we = 1'b0;
      re_a = 1'b1; raddr_a = 4'd3; re_b = 1'b1; raddr_b = 4'd15;
      cyc();
      chk("rd_a_3", 64'(rdata_a), 64'h3C);
      chk("rd_b_15", 64'(rdata_b), 64'hF0);
      chk("rd_vld", 64'({rvld_a, rvld_b}), 64'h3);
      re_a = 1'b0; re_b = 1'b0;
      cyc();
      chk("idle_vld", 64'({rvld_a, rvld_b}), 64'h0);
      chk("hold_a", 64'(rdata_a), 64'h3C);
      chk("hold_b", 64'(rdata_b), 64'hF0);

      // ---------------- bypass ----------------
      we = 1'b1; waddr = 4'd7; wdata = 8'h11;
      cyc();
      wdata = 8'h22; re_a = 1'b1; raddr_a = 4'd7;
      cyc();
      chk("bypass_a", 64'(rdata_a), 64'h22);
      chk("bypass_rf_data", 64'(rf_data), 64'h003C000000);
      re_a = 1'b0; waddr = 4'd2; wdata = 8'h5A;
      cyc();
      chk("wr2_rf_slice", 64'(rf_data[23:16]), 64'h5A);
      chk("wr2_rf_data", 64'(rf_data), 64'h003C5A0000);
      // both ports bypass the same address
      waddr = 4'd9; wdata = 8'h99;
      re_a = 1'b1; raddr_a = 4'd9; re_b = 1'b1; raddr_b = 4'd9;
      cyc();
      chk("dual_bypass_a", 64'(rdata_a), 64'h99);
      chk("dual_bypass_b", 64'(rdata_b), 64'h99);
      we = 1'b0; raddr_a = 4'd7; re_b = 1'b0;
      cyc();
      chk("rd_7", 64'(rdata_a), 64'h22);
      re_a = 1'b0;

      // ---------------- clear sequence ----------------
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; waddr = 4'(i); wdata = 8'(i + 1);
         cyc();
      end
      we = 1'b0;
      chk("fill_rf_data", 64'(rf_data), 64'h0504030201);
      clr_req = 1'b1;
      cyc();                                   // edge N
      clr_req = 1'b0;
      chk("clr_busy_n", 64'(busy), 64'h1);
      cyc();                                   // N+1
      chk("clr_busy_n1", 64'(busy), 64'h1);
      chk("clr_rf_data_n1", 64'(rf_data), 64'h0504030200);
      cyc();                                   // N+2
      chk("clr_busy_n2", 64'(busy), 64'h1);
      re_a = 1'b1; raddr_a = 4'd15; re_b = 1'b1; raddr_b = 4'd0;
      cyc();                                   // N+3
      chk("clr_rd_15", 64'(rdata_a), 64'h10);
      chk("clr_rd_0", 64'(rdata_b), 64'h00);
      // dropped write plus ignored clr_req
      re_a = 1'b0; re_b = 1'b0;
      we = 1'b1; waddr = 4'd9; wdata = 8'h77; clr_req = 1'b1;
      cyc();                                   // N+4
      we = 1'b0; clr_req = 1'b0;
      chk("wr_err_pulse", 64'(wr_err), 64'h1);
      cyc();                                   // N+5
      chk("wr_err_clear", 64'(wr_err), 64'h0);
      // entry 5 is being cleared at N+6, entry 6 is not yet
      re_a = 1'b1; raddr_a = 4'd5; re_b = 1'b1; raddr_b = 4'd6;
      cyc();                                   // N+6
      chk("clr_rd_cur", 64'(rdata_a), 64'h00);
      chk("clr_rd_next", 64'(rdata_b), 64'h07);
      re_a = 1'b0; re_b = 1'b0;
      fall = 0;
      for (int k = 7; k <= 40; k++) begin
         cyc();
         if (!busy) begin
            fall = k;
            break;
         end
      end
      chk("clr_len", 64'(fall), 64'd16);
      for (int i = 0; i < 8; i++) begin
         re_a = 1'b1; raddr_a = 4'(i);
         re_b = 1'b1; raddr_b = 4'(i + 8);
         cyc();
         chk("post_clr_a", 64'(rdata_a), 64'h0);
         chk("post_clr_b", 64'(rdata_b), 64'h0);
      end
      re_a = 1'b0; re_b = 1'b0;
      we = 1'b1; waddr = 4'd1; wdata = 8'hAB;
      cyc();
      we = 1'b0;
      chk("post_clr_wr", 64'(rf_data), 64'h000000AB00);

      // ---------------- reset mid-clear ----------------
      for (int i = 10; i < 16; i++) begin
         we = 1'b1; waddr = 4'(i); wdata = 8'hFF;
         cyc();
      end
      for (int i = 0; i < 5; i++) begin
         we = 1'b1; waddr = 4'(i); wdata = 8'hEE;
         cyc();
      end
      we = 1'b0;
      chk("pre_mid_rf_data", 64'(rf_data), 64'hEEEEEEEEEE);
      clr_req = 1'b1;
      cyc();                                   // edge M, pointer 0
      clr_req = 1'b0;
      for (int i = 0; i < 6; i++) cyc();       // pointer now 6
      chk("mid_busy", 64'(busy), 64'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'h0);
      chk("mid_rst_rf_data", 64'(rf_data), 64'h0);
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         re_a = 1'b1; raddr_a = 4'(i);
         re_b = 1'b1; raddr_b = 4'(i + 8);
         cyc();
         chk("mid_rst_rd_a", 64'(rdata_a), 64'h0);
         chk("mid_rst_rd_b", 64'(rdata_b), 64'h0);
      end
      re_a = 1'b0; re_b = 1'b0;
      clr_req = 1'b1;
      cyc();
      clr_req = 1'b0;
      chk("reclr_busy", 64'(busy), 64'h1);
      fall = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         if (!busy) begin
            fall = k;
            break;
         end
      end
      chk("reclr_len", 64'(fall), 64'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
